cra: RTL and testbench

- Parameterised unsigned ripple-carry adder (CRA) with a registered result.
- Adds two WIDTH-bit operands and produces a (WIDTH+1)-bit sum; the MSB is the final carry-out.
- Built as a chain of full-adder cells. Serves as the ripple-carry baseline in adder comparison/datapath experiments.

---
 rtl/cra_pkg.sv | 16 +
 rtl/cra_if.sv | 24 ++
 rtl/cra_full_adder.sv | 16 +
 rtl/cra.sv | 63 ++++++
 tb/tb_cra.sv | 130 +++++++++++++
 5 files changed

// File: rtl/cra_pkg.sv
// Shared constants and types for the ripple-carry adder slice.
// CRA_IN_REG_EN selects the two-stage (input + output register) build.
package cra_pkg;

  localparam int CRA_DEFAULT_WIDTH = 8;

`ifdef CRA_IN_REG_EN
  localparam int CRA_LATENCY = 2;
`else
  localparam int CRA_LATENCY = 1;
`endif

  typedef logic [CRA_DEFAULT_WIDTH-1:0] cra_operand_t;
  typedef logic [CRA_DEFAULT_WIDTH:0]   cra_sum_t;

endpackage

// File: rtl/cra_if.sv
// Operand/result bundle between a producer (master) and the adder (slave).
interface cra_if
  import cra_pkg::*;
#(
  parameter int WIDTH = CRA_DEFAULT_WIDTH
);

  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             in_valid;
  logic [WIDTH:0]   sum;
  logic             out_valid;

  modport master (
    output A, B, in_valid,
    input  sum, out_valid
  );

  modport slave (
    input  A, B, in_valid,
    output sum, out_valid
  );

endinterface

// File: rtl/cra_full_adder.sv
// One-bit full-adder cell; the adder is a straight chain of these.
module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);

  logic p;

  assign p    = a ^ b;
  assign s    = p ^ cin;
  assign cout = (a & b) | (cin & p);

endmodule

// File: rtl/cra.sv
// Registered unsigned ripple-carry adder, sum is WIDTH+1 bits (MSB = carry-out).
// Define CRA_IN_REG_EN to add an input register stage (latency 2 instead of 1).
module cra
  import cra_pkg::*;
#(
  parameter int WIDTH = CRA_DEFAULT_WIDTH
) (
  input logic   clk,
  input logic   rst,
  cra_if.slave  bus
);

  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic             op_valid;
  logic [WIDTH-1:0] s;
  logic [WIDTH:0]   carry;

`ifdef CRA_IN_REG_EN
  // Input stage: the ripple chain only ever sees registered operands.
  always_ff @(posedge clk) begin
    if (rst) begin
      op_a     <= '0;
      op_b     <= '0;
      op_valid <= 1'b0;
    end else begin
      op_a     <= bus.A;
      op_b     <= bus.B;
      op_valid <= bus.in_valid;
    end
  end
`else
  assign op_a     = bus.A;
  assign op_b     = bus.B;
  assign op_valid = bus.in_valid;
`endif

  assign carry[0] = 1'b0;

  for (genvar i = 0; i < WIDTH; i++) begin : g_chain
    full_adder u_fa (
      .a    (op_a[i]),
      .b    (op_b[i]),
      .cin  (carry[i]),
      .s    (s[i]),
      .cout (carry[i+1])
    );
  end

  // Result only loads on a valid launch, so idle-cycle operands never reach sum.
  always_ff @(posedge clk) begin
    if (rst) begin
      bus.sum       <= '0;
      bus.out_valid <= 1'b0;
    end else begin
      if (op_valid) begin
        bus.sum <= {carry[WIDTH], s};
      end
      bus.out_valid <= op_valid;
    end
  end

endmodule

// File: tb/tb_cra.sv
// Self-checking bench for cra: directed vectors plus randomized stream vs. arithmetic model.
module tb_cra;
  import cra_pkg::*;

  localparam int W = 8;

  logic clk;
  logic rst;

  cra_if #(.WIDTH(W)) bus ();

  cra #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checkCount = 0;
  int passCount  = 0;

  // Reference: results in flight through the input stages, plus what the output should show.
  logic       pendValid[$];
  logic [W:0] pendSum[$];
  logic [W:0] expSum;
  logic       expValid;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checkCount++;
    if (observed === expected) begin
      passCount++;
    end else begin
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
    end
  endtask

  task automatic flushModel();
    pendValid.delete();
    pendSum.delete();
    for (int i = 0; i < CRA_LATENCY - 1; i++) begin
      pendValid.push_back(1'b0);
      pendSum.push_back('0);
    end
  endtask

  task automatic applyStimulus(input logic [W-1:0] a, input logic [W-1:0] b, input logic v, input logic r);
    logic       headValid;
    logic [W:0] headSum;
    bus.A        = a;
    bus.B        = b;
    bus.in_valid = v;
    rst          = r;
    @(posedge clk);
    #1;
    if (r) begin
      flushModel();
      expSum   = '0;
      expValid = 1'b0;
    end else begin
      pendValid.push_back(v);
      pendSum.push_back((W+1)'(a) + (W+1)'(b));
      headValid = pendValid.pop_front();
      headSum   = pendSum.pop_front();
      if (headValid) expSum = headSum;
      expValid = headValid;
    end
    checkOutput("sum", 32'(bus.sum), 32'(expSum));
    checkOutput("out_valid", 32'(bus.out_valid), 32'(expValid));
  endtask

  // Launch one pair, idle until it reaches the output, then compare against a fixed value.
  task automatic directed(input string tag, input logic [W-1:0] a, input logic [W-1:0] b, input int expected);
    applyStimulus(a, b, 1'b1, 1'b0);
    for (int i = 0; i < CRA_LATENCY - 1; i++) applyStimulus(W'($urandom), W'($urandom), 1'b0, 1'b0);
    checkOutput(tag, 32'(bus.sum), 32'(expected));
  endtask

  initial begin
    logic [W-1:0] ra, rb;
    logic         rv, rr;
    int streamA[5] = '{12, 3, 200, 23, 0};
    int streamB[5] = '{124, 10, 30, 100, 0};
    int streamS[5] = '{136, 13, 230, 123, 0};

    flushModel();
    expSum   = '0;
    expValid = 1'b0;

    // Reset dominates a valid input.
    for (int i = 0; i < 3; i++) begin
      applyStimulus(8'd255, 8'd255, 1'b1, 1'b1);
      checkOutput("reset_sum", 32'(bus.sum), 32'd0);
      checkOutput("reset_valid", 32'(bus.out_valid), 32'd0);
    end

    directed("carry_out", 8'd255, 8'd122, 377);
    directed("max_sum", 8'd255, 8'd255, 510);
    directed("full_ripple", 8'h01, 8'hFF, 256);
    directed("alternating", 8'hAA, 8'h55, 255);

    // Back-to-back stream; the model checks each result at the build's latency.
    for (int i = 0; i < 5; i++) applyStimulus(W'(streamA[i]), W'(streamB[i]), 1'b1, 1'b0);
    for (int i = 0; i < CRA_LATENCY - 1; i++) applyStimulus(8'd0, 8'd0, 1'b0, 1'b0);
    checkOutput("stream_last", 32'(bus.sum), 32'(streamS[4]));

    // Hold: idle cycles with junk operands leave sum alone and drop out_valid.
    directed("hold_load", 8'd200, 8'd30, 230);
    for (int i = 0; i < 4; i++) begin
      applyStimulus(W'($urandom), W'($urandom), 1'b0, 1'b0);
      checkOutput("hold_sum", 32'(bus.sum), 32'd230);
      checkOutput("hold_valid", 32'(bus.out_valid), 32'd0);
    end

    // Randomized stream with gaps and occasional mid-stream resets.
    for (int i = 0; i < 1000; i++) begin
      ra = W'($urandom);
      rb = W'($urandom);
      rv = ($urandom_range(0, 3) != 0);
      rr = ($urandom_range(0, 99) == 0);
      applyStimulus(ra, rb, rv, rr);
    end
    for (int i = 0; i < CRA_LATENCY; i++) applyStimulus(8'd0, 8'd0, 1'b0, 1'b0);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
